// File: rtl/cpu_pkg.sv
// Shared core types and constants used by the fetch stage.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd1;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer of {pc, data} entries with push, pop and flush.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [XLEN-1:0]              push_pc,
  input  logic [XLEN-1:0]              push_data,
  input  logic                         pop,
  output logic [XLEN-1:0]              head_pc,
  output logic [XLEN-1:0]              head_data,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  assign head_pc   = mem[rd_ptr].pc;
  assign head_data = mem[rd_ptr].data;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: push_pc, data: push_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request, response buffer for decode.
// Optional FETCH_BYPASS_EN forwards a response to decode in the same cycle when the buffer is empty.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   tag_pc;
  logic          outstanding;
  logic          drop;
  logic [CW-1:0] count;
  logic [31:0]   head_pc;
  logic [31:0]   head_data;
  logic          buf_empty;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_accept;
  logic          push;
  logic          pop;

  // Handshakes: a transfer happens on a cycle where valid && ready are both high;
  // valid may drop before acceptance (imem tolerates withdrawal), payload is stable while valid.
  assign imem_req_valid = rst_n && !outstanding && !drop && (count < CW'(DEPTH)) && !redirect;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is stray (e.g. after reset) and ignored.
  assign rsp_fire   = imem_rsp_valid && outstanding;
  assign rsp_accept = rsp_fire && !drop && !redirect;
  assign buf_empty  = (count == '0);
  assign pop        = !buf_empty && inst_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = rsp_accept && buf_empty;
  assign inst_valid = !buf_empty || bypass;
  assign inst_data  = bypass ? imem_rsp_data : head_data;
  assign inst_pc    = bypass ? tag_pc : head_pc;
  assign push       = rsp_accept && !(bypass && inst_ready);
`else
  assign inst_valid = !buf_empty;
  assign inst_data  = head_data;
  assign inst_pc    = head_pc;
  assign push       = rsp_accept;
`endif

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_pc   (tag_pc),
    .push_data (imem_rsp_data),
    .pop       (pop),
    .head_pc   (head_pc),
    .head_data (head_data),
    .count     (count)
  );

  // Redirect and request never coincide because the request is gated by redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      tag_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_addr;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (req_fire) begin
        tag_pc <= fetch_pc;
      end
      if (req_fire) begin
        outstanding <= 1'b1;
      end else if (rsp_fire) begin
        outstanding <= 1'b0;
      end
      // The stale response of a redirected request must be discarded when it lands.
      if (rsp_fire) begin
        drop <= 1'b0;
      end else if (redirect && outstanding) begin
        drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable imem responder.
module tb_fetch_unit;
  import cpu_pkg::*;

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] req_addr_q[$];
  logic [31:0] req_cyc_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_data_q[$];
  logic [31:0] pop_cyc_q[$];
  logic [31:0] exp_q[$];

  logic        iv_log [64];
  logic        rv_log [64];
  logic [31:0] ra_log [64];

  int          lat;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  bit          hs;
  logic [31:0] hs_addr;
  int          cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock: sample at negedge, then drive the imem response for the next cycle.
  task automatic cycle();
    @(negedge clk);
    hs      = imem_req_valid && imem_req_ready;
    hs_addr = imem_req_addr;
    if (cyc < 64) begin
      iv_log[cyc] = inst_valid;
      rv_log[cyc] = imem_req_valid;
      ra_log[cyc] = imem_req_addr;
    end
    if (hs) begin
      req_addr_q.push_back(imem_req_addr);
      req_cyc_q.push_back(32'(cyc));
    end
    if (inst_valid && inst_ready) begin
      pop_pc_q.push_back(inst_pc);
      pop_data_q.push_back(inst_data);
      pop_cyc_q.push_back(32'(cyc));
    end
    cyc++;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (hs) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
      mem_addr = hs_addr;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h100 + mem_addr;
        mem_busy       = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_addr  = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b1;
    lat            = 1;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    cyc            = 0;
    req_addr_q.delete();
    req_cyc_q.delete();
    pop_pc_q.delete();
    pop_data_q.delete();
    pop_cyc_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC_DEFAULT);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int found;
    int idx5;
    int rc;
    int mark;
    int n5;

    // Sequential fetch, 1-cycle memory, decode always ready.
    do_reset();
    repeat (10) cycle();
    check("t1_first_req_valid", 32'(rv_log[0]), 32'd1);
    check("t1_npop", 32'(pop_pc_q.size() >= 4), 32'd1);
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check($sformatf("t1_req_addr%0d", k), qat(req_addr_q, k), e);
      check($sformatf("t1_req_cyc%0d", k), qat(req_cyc_q, k), 32'(2 * k));
      check($sformatf("t1_pop_pc%0d", k), qat(pop_pc_q, k), e);
      check($sformatf("t1_pop_data%0d", k), qat(pop_data_q, k), 32'h100 + e);
      check($sformatf("t1_pop_cyc%0d", k), qat(pop_cyc_q, k), 32'(2 + 2 * k - BYP));
    end

    // Decode stalled: buffer fills, requests stop, resume after first pop.
    do_reset();
    inst_ready = 1'b0;
    repeat (8) cycle();
    check("t2_nreq", 32'(req_addr_q.size()), 32'd2);
    check("t2_count", 32'(dut.u_fifo.count), 32'd2);
    check("t2_req_valid_full", 32'(rv_log[7]), 32'd0);
    check("t2_inst_valid", 32'(iv_log[7]), 32'd1);
    inst_ready = 1'b1;
    repeat (4) cycle();
    check("t2_pop_cyc0", qat(pop_cyc_q, 0), 32'd8);
    check("t2_pop_pc0", qat(pop_pc_q, 0), 32'd0);
    check("t2_pop_pc1", qat(pop_pc_q, 1), 32'd1);
    check("t2_resume_addr", qat(req_addr_q, 2), 32'd2);
    check("t2_resume_cyc", qat(req_cyc_q, 2), 32'd9);

    // Redirect to 0x40 while the request to 5 is in flight (3-cycle memory).
    do_reset();
    lat   = 3;
    found = 0;
    idx5  = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      cycle();
      if (req_addr_q.size() > 0 && req_addr_q[req_addr_q.size() - 1] == 32'd5) begin
        found = 1;
        idx5  = req_addr_q.size() - 1;
      end
    end
    check("t3_found_req5", 32'(found), 32'd1);
    rc            = cyc - 1;
    mark          = pop_pc_q.size();
    redirect      = 1'b1;
    redirect_addr = 32'h40;
    cycle();
    redirect = 1'b0;
    repeat (12) cycle();
    check("t3_pops_before", 32'(mark), 32'd5);
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(k));
    for (int k = 0; k < 5; k++) check($sformatf("t3_pre_pc%0d", k), qat(pop_pc_q, k), exp_q.pop_front());
    check("t3_next_req", qat(req_addr_q, idx5 + 1), 32'h40);
    check("t3_next_req_cyc", qat(req_cyc_q, idx5 + 1), 32'(rc + 4));
    check("t3_next_pop_pc", qat(pop_pc_q, mark), 32'h40);
    check("t3_next_pop_data", qat(pop_data_q, mark), 32'h140);
    n5 = 0;
    foreach (pop_pc_q[k]) if (pop_pc_q[k] == 32'd5) n5++;
    check("t3_no_pc5", 32'(n5), 32'd0);

    // Redirect coincides with a response and a ready decode.
    do_reset();
    cycle();
    redirect      = 1'b1;
    redirect_addr = 32'h80;
    cycle();
    redirect = 1'b0;
    repeat (5) cycle();
    check("t4_iv_redirect_cyc", 32'(iv_log[1]), 32'd0);
    check("t4_iv_after", 32'(iv_log[2]), 32'd0);
    check("t4_req_valid", 32'(rv_log[2]), 32'd1);
    check("t4_req_addr", ra_log[2], 32'h80);
    check("t4_req_log", qat(req_addr_q, 1), 32'h80);
    check("t4_pop_pc", qat(pop_pc_q, 0), 32'h80);
    check("t4_pop_data", qat(pop_data_q, 0), 32'h180);

    // PC wrap from FFFF_FFFF to 0.
    do_reset();
    redirect      = 1'b1;
    redirect_addr = 32'hFFFF_FFFF;
    cycle();
    redirect = 1'b0;
    repeat (6) cycle();
    check("t5_no_req_on_redirect", 32'(rv_log[0]), 32'd0);
    check("t5_req0_addr", qat(req_addr_q, 0), 32'hFFFF_FFFF);
    check("t5_req0_cyc", qat(req_cyc_q, 0), 32'd1);
    check("t5_req1_addr", qat(req_addr_q, 1), 32'd0);
    check("t5_req1_cyc", qat(req_cyc_q, 1), 32'd3);
    check("t5_pop_pc", qat(pop_pc_q, 0), 32'hFFFF_FFFF);
    check("t5_pop_data", qat(pop_data_q, 0), 32'h0000_00FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
